// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response and decode handshake.
// master = fetch_queue side, slave = memory/decode environment side.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rsp_valid;
  logic [WIDTH-1:0] imem_rsp_data;
  logic             dec_valid;
  logic [WIDTH-1:0] dec_instr;
  logic [WIDTH-1:0] dec_pc;
  logic             dec_ready;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_rsp_valid, imem_rsp_data, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_rsp_valid, imem_rsp_data, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one memory request in flight,
// and buffers {instr, pc} pairs in a small FIFO ahead of the IF/ID register.
//
// state        | meaning
// S_IDLE       | nothing outstanding; may issue when FIFO has room
// S_WAIT       | live request outstanding; response gets pushed
// S_WAIT_STALE | outstanding request predates a redirect; response dropped
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [WIDTH-1:0]           redirect_pc,
  fetch_queue_if.master              bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_WAIT_STALE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic             issue;
  logic             push;
  logic             pop;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        issue = !rst && (count < DEPTH_C) && !redirect_valid;
        if (issue) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        push = bus.imem_rsp_valid && !redirect_valid;
        // A redirect with the response in the same cycle leaves nothing to wait for.
        if (bus.imem_rsp_valid)     state_nxt = S_IDLE;
        else if (redirect_valid)    state_nxt = S_WAIT_STALE;
      end
      S_WAIT_STALE: begin
        if (bus.imem_rsp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pop           = bus.dec_valid && bus.dec_ready && !redirect_valid;
  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_instr = mem_instr[rd_ptr];
  assign bus.dec_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + WIDTH'(4);
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= bus.imem_rsp_data;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios pinned with literal values,
// then randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [WIDTH-1:0] redirect_pc = '0;
  logic [CW-1:0]    count;

  fetch_queue_if #(.WIDTH(WIDTH)) bus ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus.master),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  // memory model: one pending response
  bit pend = 0;
  int due  = 0;

  // reference model
  logic [63:0] m_q[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_out_pc;
  logic [31:0] m_fetch;

  // last observed DUT outputs, for literal pins
  logic        obs_req, obs_dv;
  logic [31:0] obs_addr, obs_pc;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out    = 0;
    m_stale  = 0;
    m_out_pc = '0;
    m_fetch  = 32'h0;
    pend     = 0;
    bus.imem_rsp_valid = 1'b0;
  endtask

  // Hold reset for a couple of edges; the next step() releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_req"},   64'(bus.imem_req),  64'h0);
    chk({tag, "_dv"},    64'(bus.dec_valid), 64'h0);
    chk({tag, "_cnt"},   64'(count),         64'h0);
    chk({tag, "_instr"}, 64'(bus.dec_instr), 64'h0);
    chk({tag, "_pc"},    64'(bus.dec_pc),    64'h0);
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          e_req, e_dv;
    logic [63:0] head;
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = rd;
    redirect_pc    = rpc;
    bus.dec_ready  = rdy;
    if (pend && cyc == due) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = $urandom;
      pend = 0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    e_req = !m_out && (m_q.size() < DEPTH) && !rd;
    e_dv  = (m_q.size() != 0);
    chk("imem_req", 64'(bus.imem_req), 64'(e_req));
    if (e_req) chk("imem_addr", 64'(bus.imem_addr), 64'(m_fetch));
    chk("dec_valid", 64'(bus.dec_valid), 64'(e_dv));
    if (e_dv) begin
      head = m_q[0];
      chk("dec_instr", 64'(bus.dec_instr), 64'(head[63:32]));
      chk("dec_pc",    64'(bus.dec_pc),    64'(head[31:0]));
    end
    chk("count", 64'(count), 64'(m_q.size()));
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    obs_dv   = bus.dec_valid;
    obs_pc   = bus.dec_pc;
    obs_cnt  = count;
    if (bus.imem_req && !pend) begin
      pend = 1;
      due  = cyc + lat;
    end
    // model advance for the coming clock edge
    if (rd) begin
      m_q.delete();
      m_fetch = rpc;
      if (m_out) begin
        if (bus.imem_rsp_valid) m_out = 0;
        else                    m_stale = 1;
      end
    end else begin
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (m_out && bus.imem_rsp_valid) begin
        if (!m_stale) m_q.push_back({bus.imem_rsp_data, m_out_pc});
        m_out   = 0;
        m_stale = 0;
      end
      if (e_req) begin
        m_out    = 1;
        m_stale  = 0;
        m_out_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.dec_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset release, L=1, always ready
    lat = 1;
    step(0, 0, 1); chk("p1_req0", 64'(obs_req), 64'h1); chk("p1_addr0", 64'(obs_addr), 64'h0);
    step(0, 0, 1); chk("p1_req1", 64'(obs_req), 64'h0);
    step(0, 0, 1); chk("p1_addr4", 64'(obs_addr), 64'h4); chk("p1_pc0", 64'(obs_pc), 64'h0);
    chk("p1_dv2", 64'(obs_dv), 64'h1);
    step(0, 0, 1); chk("p1_dv3", 64'(obs_dv), 64'h0);
    step(0, 0, 1); chk("p1_addr8", 64'(obs_addr), 64'h8); chk("p1_pc4", 64'(obs_pc), 64'h4);
    step(0, 0, 1);
    step(0, 0, 1); chk("p1_pc8", 64'(obs_pc), 64'h8);

    // Backpressure fills the FIFO, then drains in order
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("p2_cnt4", 64'(obs_cnt), 64'h4);
    chk("p2_noreq", 64'(obs_req), 64'h0);
    step(0, 0, 1); chk("p2_pop0", 64'(obs_pc), 64'h0); chk("p2_full_noreq", 64'(obs_req), 64'h0);
    step(0, 0, 1); chk("p2_pop4", 64'(obs_pc), 64'h4); chk("p2_resume", 64'(obs_addr), 64'h10);
    step(0, 0, 1); chk("p2_pop8", 64'(obs_pc), 64'h8); chk("p2_cnt2a", 64'(obs_cnt), 64'h2);
    step(0, 0, 1); chk("p2_popC", 64'(obs_pc), 64'hC); chk("p2_cnt2b", 64'(obs_cnt), 64'h2);

    // Redirect with FIFO holding 0x0..0x8, nothing outstanding
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    step(1, 32'h40, 1); chk("p3_cnt3", 64'(obs_cnt), 64'h3); chk("p3_noreq", 64'(obs_req), 64'h0);
    step(0, 0, 1);
    chk("p3_cnt0", 64'(obs_cnt), 64'h0); chk("p3_dv0", 64'(obs_dv), 64'h0);
    chk("p3_req", 64'(obs_req), 64'h1); chk("p3_addr40", 64'(obs_addr), 64'h40);
    step(0, 0, 1);
    step(0, 0, 1); chk("p3_dv", 64'(obs_dv), 64'h1); chk("p3_pc40", 64'(obs_pc), 64'h40);

    // Redirect while 0x10 is outstanding with L=3
    do_reset();
    lat = 1;
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    lat = 3;
    step(0, 0, 1); chk("p4_addr10", 64'(obs_addr), 64'h10);
    step(1, 32'h80, 1);
    step(0, 0, 1); chk("p4_stall1", 64'(obs_req), 64'h0);
    step(0, 0, 1); chk("p4_stall2", 64'(obs_req), 64'h0);
    step(0, 0, 1); chk("p4_req80", 64'(obs_req), 64'h1); chk("p4_addr80", 64'(obs_addr), 64'h80);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1); chk("p4_pc80", 64'(obs_pc), 64'h80); chk("p4_dv", 64'(obs_dv), 64'h1);

    // Async reset mid-WAIT with three entries buffered
    do_reset();
    lat = 3;
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("p5_cnt3", 64'(obs_cnt), 64'h3);
    async_reset("p5_rst");
    lat = 1;
    step(0, 0, 1); chk("p5_req", 64'(obs_req), 64'h1); chk("p5_addr0", 64'(obs_addr), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [31:0] rpc;
      lat = $urandom_range(1, 4);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(rd, rpc, ($urandom_range(0, 9) < 7));
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
